// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO controller.
//   DefDataWidth / DefAddrWidth : default word width and pointer width
//   count_width()               : bits needed to hold an occupancy of 0..2**addr_width
//   count_t                     : occupancy type for the default geometry
package fifo_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefAddrWidth = 6;

    // One extra bit so the occupancy can represent a completely full FIFO.
    function automatic int unsigned count_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    typedef logic [DefAddrWidth:0] count_t;

endpackage

// File: rtl/simple_dual_port_ram_single_clock.sv
// Simple dual-port RAM, one clock, registered read port.
//   clk_i   : clock
//   we_i    : write enable; wdata_i stored at waddr_i on the rising edge
//   re_i    : read enable; rdata_o loads mem[raddr_i] on the rising edge
//   rdata_o : registered read data; a read of the address being written
//             in the same cycle returns the old contents
// Contents and read register are deliberately not reset.
module simple_dual_port_ram_single_clock #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned AddrWidth = 6
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [DataWidth-1:0] rdata_o
);

    localparam int unsigned Depth = 2 ** AddrWidth;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Non-blocking update means a same-address read sees the pre-write word.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO: pointer/occupancy/flag control around a registered-read RAM.
//   clk       : clock, all state on rising edge
//   rst       : asynchronous active-low reset
//   push/din  : write request and data
//   pop       : read request
//   dout      : read data, meaningful only while rd_valid=1
//   rd_valid  : dout carries the word of the pop accepted on the previous edge
//   full      : count == DEPTH (registered)
//   empty     : count == 0 (registered)
//   count     : stored words, 0..DEPTH
//   overflow  : sticky, a push was refused because the FIFO was full
//   underflow : sticky, a pop was attempted while empty
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  logic [DATA_WIDTH-1:0]             din,
    input  logic                              pop,
    output logic [DATA_WIDTH-1:0]             dout,
    output logic                              rd_valid,
    output logic                              full,
    output logic                              empty,
    output logic [count_width(ADDR_WIDTH)-1:0] count,
    output logic                              overflow,
    output logic                              underflow
);

    localparam int unsigned CountWidth = count_width(ADDR_WIDTH);
    localparam logic [CountWidth-1:0] Depth = CountWidth'(2 ** ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  push_acc, pop_acc;

    // A pop frees a slot in the same cycle, so a full FIFO still takes push+pop.
    // An empty FIFO never accepts a pop, even alongside a push.
    assign pop_acc  = pop & ~empty_q;
    assign push_acc = push & (~full_q | pop_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_valid_d  = pop_acc;
        overflow_d  = overflow_q | (push & ~push_acc);
        underflow_d = underflow_q | (pop & empty_q);

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end

        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CountWidth'(1);
            2'b01:   count_d = count_q - CountWidth'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == Depth);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    simple_dual_port_ram_single_clock #(
        .DataWidth (DATA_WIDTH),
        .AddrWidth (ADDR_WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (push_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .re_i    (pop_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (dout)
    );

    assign rd_valid  = rd_valid_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
